mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: ALIGN_SPLIT, 1, 1 = split a misaligned word access into two byte accesses; 0 = reject it with err.
REQ-002 SHALL have port: clk  input  1  single clock; memory banks capture on negedge, all controller state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 SHALL have port: req  input  1  access request from datapath FSM.
REQ-005 SHALL have port: we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: size  input  1  1 = word (16b), 0 = byte.
REQ-007 SHALL have port: addr  input  16  byte address.
REQ-008 SHALL have port: wdata  input  16  store data; byte store uses wdata[7:0].
REQ-009 SHALL have port: ready  output  1  controller idle, request accepted this cycle if req=1.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, access complete.
REQ-011 SHALL have port: rdata  output  16  load result, valid while done=1 and held until the next done.
REQ-012 SHALL have port: err  output  1  one-cycle pulse with done for a rejected access.
REQ-013 SHALL have port: mem_addr  output  16  address to 16-bit memory.
REQ-014 SHALL have port: mem_in  output  16  write data to memory.
REQ-015 SHALL have port: mem_write  output  1  active-low write strobe.
REQ-016 SHALL have port: mem_size  output  1  1 = word mode, 0 = byte mode (drives memory ir14).
REQ-017 SHALL have port: mem_out  input  16  memory read data; byte mode arrives sign-extended.

Function
REQ-018 SHALL implement states IDLE, ACC1, ACC2, DONE; ready=1 only in IDLE.
REQ-019 SHALL, in IDLE with req=1, latch we/size/addr/wdata and enter ACC1; later changes on the request inputs SHALL be ignored until the next IDLE.
REQ-020 SHALL classify the latched access as aligned when size=0 or addr[0]=0, otherwise misaligned.
REQ-021 SHALL, for an aligned access in ACC1, drive mem_addr=addr and mem_size=size; for a store, also drive mem_write=0 and mem_in=wdata (word) or {wdata[7:0],wdata[7:0]} (byte).
REQ-022 SHALL, at the posedge ending ACC1 (aligned load), capture mem_out: rdata=mem_out for word loads and rdata=mem_out (sign-extended byte) for byte loads; then enter DONE.
REQ-023 SHALL, for a misaligned access with ALIGN_SPLIT=1, use byte mode in both ACC1 and ACC2: ACC1 accesses addr with low byte wdata[7:0]; ACC2 accesses addr+1 (16-bit wrap, 0xFFFF+1=0x0000) with high byte wdata[15:8].
REQ-024 SHALL, for a split load, set rdata={mem_out[7:0] from ACC2, mem_out[7:0] from ACC1}; the sign extension from the memory SHALL be discarded.
REQ-025 SHALL, for a misaligned access with ALIGN_SPLIT=0, go IDLE->DONE with no memory access (mem_write stays 1), pulse err=1 with done, and leave rdata unchanged.
REQ-026 SHALL, in DONE, pulse done=1 for exactly one cycle and return to IDLE; a req in DONE is not accepted.
REQ-027 SHALL keep latency (accept edge to done cycle) at 2 cycles aligned, 3 cycles split, 1 cycle rejected.
REQ-028 SHALL hold mem_write=1 in IDLE, DONE and on every load, and SHALL decode it from registered state so it is glitch-free at the negedge.
REQ-029 SHALL, outside an access, drive mem_addr=0, mem_in=0 and mem_size=1.

Reset
REQ-030 SHALL, while reset=0 at a posedge, force state=IDLE, ready=1, done=0, err=0, rdata=0, mem_write=1, mem_addr=0, mem_in=0, mem_size=1.
REQ-031 SHALL let a reset sampled mid-access (ACC1/ACC2) abort the access so that no memory write occurs at the following negedge and no done is issued.

Verification
REQ-032 SHALL pass: word store addr=0x0010 wdata=0xBEEF, then word load 0x0010 -> done 2 cycles after accept, rdata=0xBEEF.
REQ-033 SHALL pass: byte store addr=0x0021 wdata=0x0080, then byte load 0x0021 -> rdata=0xFF80, and byte 0x0020 is unchanged.
REQ-034 SHALL pass with ALIGN_SPLIT=1: word store addr=0x0031 wdata=0x1234 -> byte 0x31=0x34 and byte 0x32=0x12; word load 0x0031 -> rdata=0x1234 with 3-cycle latency.
REQ-035 SHALL pass: misaligned word load at addr=0xFFFF -> ACC2 mem_addr=0x0000 (address wraps).
REQ-036 SHALL pass with ALIGN_SPLIT=0: word load at 0x0005 -> done and err pulse 1 cycle after accept, mem_write stays 1, rdata unchanged.
REQ-037 SHALL pass: reset=0 asserted during ACC1 of a store to 0x0040 -> memory byte 0x40 unchanged, ready=1 after the edge, no done.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a datapath FSM and a 16-bit byte-addressed memory.
// Aligned accesses take one memory cycle; misaligned words are split into two byte accesses or rejected.
module mem_access_ctrl #(
  parameter int ALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_in,
  output logic        mem_write,
  output logic        mem_size,
  input  logic [15:0] mem_out,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken at the posedge where req=1 and ready=1;
  // done pulses for one cycle when the access completes, with err for a rejected one.

  typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic        l_we;
  logic        l_split;
  logic [15:0] l_addr;
  logic [7:0]  l_hi;
  logic [7:0]  lo_byte;
  logic        mem_write_q;
  logic        mis_in;

  assign mis_in    = size & addr[0];
  assign ready     = (state == IDLE);
  assign dbg_state = state;

  // Reset gates the strobe immediately so an access aborted mid-cycle never reaches the negedge.
  assign mem_write = mem_write_q | ~reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= 16'h0000;
      mem_write_q <= 1'b1;
      mem_addr    <= 16'h0000;
      mem_in      <= 16'h0000;
      mem_size    <= 1'b1;
      l_we        <= 1'b0;
      l_split     <= 1'b0;
      l_addr      <= 16'h0000;
      l_hi        <= 8'h00;
      lo_byte     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            l_we    <= we;
            l_split <= mis_in;
            l_addr  <= addr;
            l_hi    <= wdata[15:8];
            if (mis_in && (ALIGN_SPLIT == 0)) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state       <= ACC1;
              mem_addr    <= addr;
              mem_size    <= size & ~mis_in;
              mem_write_q <= ~we;
              if (!we)
                mem_in <= 16'h0000;
              else if (size && !mis_in)
                mem_in <= wdata;
              else
                mem_in <= {wdata[7:0], wdata[7:0]};
            end
          end
        end
        ACC1: begin
          if (l_split) begin
            state       <= ACC2;
            lo_byte     <= mem_out[7:0];
            mem_addr    <= l_addr + 16'd1;
            mem_size    <= 1'b0;
            mem_write_q <= ~l_we;
            mem_in      <= l_we ? {l_hi, l_hi} : 16'h0000;
          end else begin
            if (!l_we)
              rdata <= mem_out;
            state       <= DONE;
            done        <= 1'b1;
            mem_addr    <= 16'h0000;
            mem_in      <= 16'h0000;
            mem_size    <= 1'b1;
            mem_write_q <= 1'b1;
          end
        end
        ACC2: begin
          // Byte reads come back sign-extended; only the raw bytes are kept.
          if (!l_we)
            rdata <= {mem_out[7:0], lo_byte};
          state       <= DONE;
          done        <= 1'b1;
          mem_addr    <= 16'h0000;
          mem_in      <= 16'h0000;
          mem_size    <= 1'b1;
          mem_write_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one splitting instance and one rejecting instance,
// each attached to a small behavioural byte memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0, size = 1'b0;
  logic [15:0] addr = 16'h0, wdata = 16'h0;

  logic        ready_a, done_a, err_a, mw_a, ms_a;
  logic [15:0] rdata_a, ma_a, mi_a, mo_a;
  logic [1:0]  st_a;
  logic        ready_b, done_b, err_b, mw_b, ms_b;
  logic [15:0] rdata_b, ma_b, mi_b, mo_b;
  logic [1:0]  st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ALIGN_SPLIT(1)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .ready(ready_a), .done(done_a), .rdata(rdata_a), .err(err_a),
    .mem_addr(ma_a), .mem_in(mi_a), .mem_write(mw_a), .mem_size(ms_a), .mem_out(mo_a),
    .dbg_state(st_a)
  );

  mem_access_ctrl #(.ALIGN_SPLIT(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .ready(ready_b), .done(done_b), .rdata(rdata_b), .err(err_b),
    .mem_addr(ma_b), .mem_in(mi_b), .mem_write(mw_b), .mem_size(ms_b), .mem_out(mo_b),
    .dbg_state(st_b)
  );

  // Byte memory for u_a, little-endian, byte lane chosen by address bit 0.
  logic [7:0] mem_a [0:65535];
  always @(negedge clk) begin
    if (!mw_a) begin
      if (ms_a) begin
        mem_a[ma_a]         <= mi_a[7:0];
        mem_a[ma_a + 16'd1] <= mi_a[15:8];
      end else begin
        mem_a[ma_a] <= ma_a[0] ? mi_a[15:8] : mi_a[7:0];
      end
    end
  end
  assign mo_a = ms_a ? {mem_a[ma_a + 16'd1], mem_a[ma_a]}
                     : {{8{mem_a[ma_a][7]}}, mem_a[ma_a]};

  // u_b only needs an address-dependent read pattern.
  assign mo_b = ma_b ^ 16'h5A5A;

  logic        cur_sel = 1'b0;
  wire         cur_done  = cur_sel ? done_b  : done_a;
  wire         cur_ready = cur_sel ? ready_b : ready_a;
  wire         cur_err   = cur_sel ? err_b   : err_a;
  wire         cur_mw    = cur_sel ? mw_b    : mw_a;
  wire  [15:0] cur_rdata = cur_sel ? rdata_b : rdata_a;
  wire  [15:0] cur_ma    = cur_sel ? ma_b    : ma_a;

  task automatic run(input bit sel, input bit w, input bit s, input logic [15:0] a,
                     input logic [15:0] d, output int lat, output logic [15:0] rd,
                     output logic e, output logic [15:0] a1, output logic [15:0] a2,
                     output bit wlow);
    bit got = 0;
    lat = 0; rd = 16'h0; e = 1'b0; a1 = 16'h0; a2 = 16'h0; wlow = 0;
    cur_sel = sel;
    @(posedge clk); #1;
    we = w; size = s; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      req_a = 1'b0; req_b = 1'b0;
      we = ~w; size = ~s; addr = ~a; wdata = ~d;
      if (cur_mw === 1'b0) wlow = 1;
      if (lat == 1) a1 = cur_ma;
      if (lat == 2) a2 = cur_ma;
      if (cur_done === 1'b1) begin
        got = 1;
        rd = cur_rdata;
        e = cur_err;
        checks++;
        if (cur_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_done: got %b want 0", cur_ready);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles addr=%h", lat, a);
    end
    we = 1'b0; size = 1'b0; addr = 16'h0; wdata = 16'h0;
  endtask

  task automatic expect16(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect16("rst_ready",   {15'b0, ready_a}, 16'h1);
    expect16("rst_done",    {15'b0, done_a},  16'h0);
    expect16("rst_err",     {15'b0, err_a},   16'h0);
    expect16("rst_rdata",   rdata_a,          16'h0);
    expect16("rst_mw",      {15'b0, mw_a},    16'h1);
    expect16("rst_maddr",   ma_a,             16'h0);
    expect16("rst_min",     mi_a,             16'h0);
    expect16("rst_msize",   {15'b0, ms_a},    16'h1);
    expect16("rst_state",   {14'b0, st_a},    16'h0);
    expect16("rst_b_ready", {15'b0, ready_b}, 16'h1);
    reset = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic [15:0] rd, a1, a2; logic e; bit wl;
    run(0, 1, 1, 16'h0010, 16'hBEEF, lat, rd, e, a1, a2, wl);
    expect16("wst_lat",  lat[15:0], 16'd2);
    expect16("wst_wlow", {15'b0, wl}, 16'h1);
    expect16("wst_mem",  {mem_a[16'h0011], mem_a[16'h0010]}, 16'hBEEF);
    run(0, 0, 1, 16'h0010, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("wld_lat",   lat[15:0], 16'd2);
    expect16("wld_rdata", rd, 16'hBEEF);
    expect16("wld_err",   {15'b0, e}, 16'h0);
    expect16("wld_wlow",  {15'b0, wl}, 16'h0);
  endtask

  task automatic test_byte();
    int lat; logic [15:0] rd, a1, a2; logic e; bit wl;
    logic [7:0] snap20;
    snap20 = mem_a[16'h0020];
    run(0, 1, 0, 16'h0021, 16'h0080, lat, rd, e, a1, a2, wl);
    expect16("bst_lat", lat[15:0], 16'd2);
    expect16("bst_mem21", {8'h0, mem_a[16'h0021]}, 16'h0080);
    expect16("bst_mem20", {8'h0, mem_a[16'h0020]}, {8'h0, snap20});
    run(0, 0, 0, 16'h0021, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("bld21_rdata", rd, 16'hFF80);
    run(0, 0, 0, 16'h0020, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("bld20_rdata", rd, {{8{snap20[7]}}, snap20});
  endtask

  task automatic test_split();
    int lat; logic [15:0] rd, a1, a2; logic e; bit wl;
    run(0, 1, 1, 16'h0031, 16'h1234, lat, rd, e, a1, a2, wl);
    expect16("sst_lat",   lat[15:0], 16'd3);
    expect16("sst_a1",    a1, 16'h0031);
    expect16("sst_a2",    a2, 16'h0032);
    expect16("sst_mem31", {8'h0, mem_a[16'h0031]}, 16'h0034);
    expect16("sst_mem32", {8'h0, mem_a[16'h0032]}, 16'h0012);
    run(0, 0, 1, 16'h0031, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("sld_lat",   lat[15:0], 16'd3);
    expect16("sld_rdata", rd, 16'h1234);
    expect16("sld_err",   {15'b0, e}, 16'h0);
    run(0, 1, 1, 16'h0051, 16'h8090, lat, rd, e, a1, a2, wl);
    run(0, 0, 1, 16'h0051, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("sld_neg_rdata", rd, 16'h8090);
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] rd, a1, a2; logic e; bit wl;
    run(0, 1, 1, 16'hFFFF, 16'hC3A5, lat, rd, e, a1, a2, wl);
    expect16("wrst_a2",     a2, 16'h0000);
    expect16("wrst_memFFFF", {8'h0, mem_a[16'hFFFF]}, 16'h00A5);
    expect16("wrst_mem0000", {8'h0, mem_a[16'h0000]}, 16'h00C3);
    run(0, 0, 1, 16'hFFFF, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("wrld_a1",    a1, 16'hFFFF);
    expect16("wrld_a2",    a2, 16'h0000);
    expect16("wrld_rdata", rd, 16'hC3A5);
  endtask

  task automatic test_reject();
    int lat; logic [15:0] rd, a1, a2; logic e; bit wl;
    run(1, 0, 1, 16'h0004, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("rj_aligned_lat",   lat[15:0], 16'd2);
    expect16("rj_aligned_rdata", rd, 16'h5A5E);
    expect16("rj_aligned_err",   {15'b0, e}, 16'h0);
    run(1, 0, 1, 16'h0005, 16'h0000, lat, rd, e, a1, a2, wl);
    expect16("rj_ld_lat",   lat[15:0], 16'd1);
    expect16("rj_ld_err",   {15'b0, e}, 16'h1);
    expect16("rj_ld_rdata", rd, 16'h5A5E);
    expect16("rj_ld_wlow",  {15'b0, wl}, 16'h0);
    run(1, 1, 1, 16'h0007, 16'hFFFF, lat, rd, e, a1, a2, wl);
    expect16("rj_st_lat",  lat[15:0], 16'd1);
    expect16("rj_st_err",  {15'b0, e}, 16'h1);
    expect16("rj_st_wlow", {15'b0, wl}, 16'h0);
  endtask

  task automatic test_abort();
    logic [7:0] s40, s41;
    bit saw_done = 0;
    s40 = mem_a[16'h0040];
    s41 = mem_a[16'h0041];
    @(posedge clk); #1;
    we = 1'b1; size = 1'b1; addr = 16'h0040; wdata = {~s41, ~s40}; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    expect16("ab_state_acc1", {14'b0, st_a}, 16'h1);
    reset = 1'b0;
    @(posedge clk); #1;
    expect16("ab_ready", {15'b0, ready_a}, 16'h1);
    expect16("ab_done",  {15'b0, done_a},  16'h0);
    expect16("ab_mem40", {8'h0, mem_a[16'h0040]}, {8'h0, s40});
    expect16("ab_mem41", {8'h0, mem_a[16'h0041]}, {8'h0, s41});
    reset = 1'b1;
    we = 1'b0; size = 1'b0; addr = 16'h0; wdata = 16'h0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) saw_done = 1;
    end
    expect16("ab_no_done", {15'b0, saw_done}, 16'h0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_split();
    test_wrap();
    test_reject();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
